// File: rtl/serial_add8.sv
// Bit-serial adder: s = a + b + ci, one bit per clock, LSB first, through a single
// full-add cell and a carry flop, with a start/busy/done handshake.
module serial_add8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             bit_sum, bit_carry, load;

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    co_d     = co_q;

    bit_sum   = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    bit_carry = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
    // The DONE cycle can take a back-to-back start so a held start yields one result per WIDTH+1 cycles.
    load      = start && ((state_q == IDLE) || (state_q == DONE));

    case (state_q)
      IDLE: state_d = IDLE;
      RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = {bit_sum, sum_sr_q[WIDTH-1:1]};
        carry_d  = bit_carry;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          s_d     = {bit_sum, sum_sr_q[WIDTH-1:1]};
          co_d    = bit_carry;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      a_sr_d  = a;
      b_sr_d  = b;
      carry_d = ci;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      s_q      <= '0;
      co_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      co_q     <= co_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;

endmodule
